seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive side of the 7-segment display interface: samples a multiplexed, active-low segment bus and per-digit enables, then recovers the 4-bit decimal value shown on each digit.
- A pattern must be stable for a programmable number of cycles before it is committed.
- Used as an on-chip display monitor and readback path, e.g. for self-check of the CPU output port against what is driven to the display.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 8, consecutive identical samples required before commit (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- seg_in  input  7  active-low segments; bit0=a … bit6=g.
- dig_en  input  DIGITS  active-high digit enable, one-hot when valid.
- err_clr  input  1  clears the sticky error.
- digits  output  4*DIGITS  decoded value per digit; nibble i = digit i.
- valid  output  DIGITS  digit i holds a committed decimal value.
- update  output  1  one-cycle pulse on each commit.
- update_idx  output  max(1,$clog2(DIGITS))  digit index of the current update.
- err  output  1  sticky: an illegal pattern was committed.
- err_idx  output  max(1,$clog2(DIGITS))  digit index of the most recent illegal pattern.

Behaviour:
- Reset: on a clk edge with rst_n=0, every output, the sample registers and the counter go to 0. Reset mid-run discards any partial stability count.
- Input stage: seg_in and dig_en are registered once (seg_q, dig_q). The previous sample is also kept (seg_p, dig_p).
- Stability counter cnt, width $clog2(STABLE_CYCLES+1), updated each edge:
  - dig_q not exactly one-hot (zero or multi-hot): cnt <= 0.
  - dig_q one-hot and {seg_q,dig_q} != {seg_p,dig_p}: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at STABLE_CYCLES.
- Commit: occurs on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES, i.e. exactly once per stable run. Holding the input longer never re-commits; the input must change and restabilise to commit again.
- Latency: let edge 0 be the first edge at which a new value reaches seg_q. The commit result is visible after edge STABLE_CYCLES (9 edges with the default).
- Decode at commit, for digit i = index of the set bit in dig_q:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1011000→7, 0000000→8, 0010000→9 (pattern written g…a): nibble i <= value, valid[i] <= 1, update=1, update_idx=i.
  - 1111111 (blank): nibble i <= 0, valid[i] <= 0, update=1, update_idx=i.
  - Any other pattern: err <= 1, err_idx <= i; nibble i and valid[i] are unchanged; no update.
- update is high for exactly one cycle per commit and low otherwise. update_idx holds its last value when update is low.
- err_clr=1 clears err on the next edge. If err_clr and a new illegal commit occur on the same edge, err is set and err_idx is updated (set wins).
- Other digits' nibbles and valid bits are never disturbed by a commit to digit i.

Test Plan:
- Reset: rst_n=0 for 3 edges with random inputs → digits=0, valid=0, update=0, err=0. Release → outputs remain 0 while dig_en=0.
- Commit: dig_en=0001, seg_in=0100100 held 20 cycles → single update pulse 8 edges after first sample, update_idx=0, digits[3:0]=2, valid=0001; no further pulse.
- Glitch and digit independence:
  - Hold digit 1 = 1011000 for 5 cycles, change seg_in to 1111001 for 1 cycle, return to 1011000 for 10 cycles → one update only, counted from the return; digits[7:4]=7, valid[1]=1.
  - digits[3:0] is unchanged throughout.
- Illegal/blank:
  - Digit 2 = 0001000 held 10 cycles → err=1, err_idx=2, no update, valid[2] unchanged.
  - Then err_clr with another illegal commit on the same edge → err stays 1.
  - Blank 1111111 on digit 0 → valid[0]=0, digits[3:0]=0, update pulse.
- Invalid enables and reset mid-run:
  - dig_en=0011 or 0000 held 20 cycles → no update, no err.
  - Pull rst_n low at cnt=6 of a stable run, then release with the same input → commit occurs 8 edges after the release, not earlier.

Source files
------------

// File: rtl/seg7_capture.sv
// seg7_capture: receive side of a multiplexed 7-segment display bus.
// Samples the active-low segment lines and one-hot digit enables, waits for
// a pattern to hold for STABLE_CYCLES consecutive samples, then commits the
// decoded decimal value (or blank) into the per-digit readback registers.
//
// Output strobe semantics: update is a single-cycle pulse, high for exactly
// one cycle per legal/blank commit; update_idx, digits and valid are already
// final in that cycle and update_idx holds its value while update is low.
// There is no back-pressure: a consumer that wants every commit must sample
// on every cycle in which update is high.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_en,
  input  logic                err_clr,
  output logic [4*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]   valid,
  output logic                update,
  output logic [IW-1:0]       update_idx,
  output logic                err,
  output logic [IW-1:0]       err_idx
);

  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_COMMIT = CW'(STABLE_CYCLES - 1);

  // Input sample and previous-sample registers
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic [6:0]        seg_p_q, seg_p_d;
  logic [DIGITS-1:0] dig_p_q, dig_p_d;

  // Stability counter
  logic [CW-1:0]     cnt_q, cnt_d;

  // Output registers
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                update_q, update_d;
  logic [IW-1:0]       update_idx_q, update_idx_d;
  logic                err_q, err_d;
  logic [IW-1:0]       err_idx_q, err_idx_d;

  // Combinational helpers
  logic          dig_onehot;
  logic          sample_same;
  logic          commit;
  logic [IW-1:0] dig_idx;
  logic          dec_legal;
  logic          dec_blank;
  logic [3:0]    dec_val;

  // Input stage: register the bus once and keep one sample of history
  always_comb begin
    seg_d   = seg_in;
    dig_d   = dig_en;
    seg_p_d = seg_q;
    dig_p_d = dig_q;
  end

  // Stability tracking: one-hot check, change detect, saturating run counter
  always_comb begin
    dig_onehot  = (dig_q != '0) && ((dig_q & (dig_q - DIGITS'(1))) == '0);
    sample_same = (seg_q == seg_p_q) && (dig_q == dig_p_q);
    cnt_d       = cnt_q;
    if (!dig_onehot) begin
      cnt_d = '0;
    end else if (!sample_same) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Commit only on the single step into saturation, so a held pattern
    // never commits twice.
    commit = dig_onehot && sample_same && (cnt_q == CNT_COMMIT);
  end

  // Index of the enabled digit (only meaningful when dig_q is one-hot)
  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[i]) dig_idx = IW'(i);
    end
  end

  // Segment decode; pattern literals are written g..a, active low
  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'd0;
    case (seg_q)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1011000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_legal = 1'b0;
    endcase
  end

  // Commit logic: update the addressed digit or flag an illegal pattern
  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    update_d     = 1'b0;
    update_idx_d = update_idx_q;
    err_d        = err_q & ~err_clr;
    err_idx_d    = err_idx_q;
    if (commit) begin
      if (dec_legal) begin
        digits_d[4*int'(dig_idx) +: 4] = dec_blank ? 4'd0 : dec_val;
        valid_d[dig_idx]               = ~dec_blank;
        update_d                       = 1'b1;
        update_idx_d                   = dig_idx;
      end else begin
        // A new illegal commit wins over a simultaneous clear.
        err_d     = 1'b1;
        err_idx_d = dig_idx;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q        <= '0;
      dig_q        <= '0;
      seg_p_q      <= '0;
      dig_p_q      <= '0;
      cnt_q        <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
      err_q        <= 1'b0;
      err_idx_q    <= '0;
    end else begin
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      seg_p_q      <= seg_p_d;
      dig_p_q      <= dig_p_d;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      update_q     <= update_d;
      update_idx_q <= update_idx_d;
      err_q        <= err_d;
      err_idx_q    <= err_idx_d;
    end
  end

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign update     = update_q;
  assign update_idx = update_idx_q;
  assign err        = err_q;
  assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: stimulus tasks for seg7_capture with a per-cycle
// scoreboard. The driver predicts commits from the driven input stream and
// queues them; the monitor pops each entry on its due edge and compares all
// outputs against a shadow model.
module tb_seg7_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 8;
  localparam int W      = 25;  // {due[15:0], kind[1:0], idx[2:0], val[3:0]}

  localparam logic [1:0] K_VAL   = 2'd1;
  localparam logic [1:0] K_BLANK = 2'd2;
  localparam logic [1:0] K_ILL   = 2'd3;

  // Reference segment table, g..a, active low
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000
  };

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic        update;
  logic [1:0]  update_idx;
  logic        err;
  logic [1:0]  err_idx;

  seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_en     (dig_en),
    .err_clr    (err_clr),
    .digits     (digits),
    .valid      (valid),
    .update     (update),
    .update_idx (update_idx),
    .err        (err),
    .err_idx    (err_idx)
  );

  // Clock and initial input values
  initial begin
    clk     = 1'b0;
    rst_n   = 1'b0;
    seg_in  = 7'h7f;
    dig_en  = 4'b0000;
    err_clr = 1'b0;
  end
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           cyc = 0;
  int           n_total = 0;
  int           n_pass = 0;
  int           upd_cnt = 0;
  int           last_upd_cyc = -1;
  int           n_pred = 0;

  // Driver-side input model
  int          run = 0;
  logic [6:0]  last_seg = '0;
  logic [3:0]  last_en = '0;

  // Monitor-side output model
  logic [15:0] m_dig = '0;
  logic [3:0]  m_val = '0;
  logic        m_err = 1'b0;
  logic [1:0]  m_eidx = '0;
  logic [1:0]  m_uidx = '0;
  logic        exp_upd = 1'b0;

  // Classify a pattern: {kind, value}
  function automatic logic [5:0] classify(input logic [6:0] seg);
    logic [5:0] r;
    r = {K_ILL, 4'd0};
    if (seg == 7'b1111111) r = {K_BLANK, 4'd0};
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG_TAB[i]) r = {K_VAL, 4'(i)};
    end
    return r;
  endfunction

  // Drive one cycle of inputs and predict any commit caused by this sample
  task automatic drive(input logic [6:0] seg, input logic [3:0] en,
                       input logic clr, input logic rst);
    logic [5:0] c;
    int         idx;
    @(negedge clk);
    seg_in  = seg;
    dig_en  = en;
    err_clr = clr;
    rst_n   = rst;
    if (!rst || ($countones(en) != 1)) begin
      run = 0;
    end else if (run > 0 && seg == last_seg && en == last_en) begin
      if (run <= STABLE) run++;
    end else begin
      run = 1;
    end
    last_seg = seg;
    last_en  = en;
    if (run == STABLE) begin
      c   = classify(seg);
      idx = 0;
      for (int i = 0; i < DIGITS; i++) if (en[i]) idx = i;
      // This sample lands on edge cyc+1; the commit is visible after cyc+2.
      exp_q.push_back({16'(cyc + 2), c[5:4], 3'(idx), c[3:0]});
      if (c[5:4] != K_ILL) n_pred++;
    end
  endtask

  // Monitor: apply due scoreboard entries and compare every output each cycle
  always @(posedge clk) begin : monitor
    logic         rst_s;
    logic         clr_s;
    logic [W-1:0] e;
    logic [1:0]   k;
    logic [1:0]   ix;
    rst_s = rst_n;
    clr_s = err_clr;
    cyc   = cyc + 1;
    #1;
    exp_upd = 1'b0;
    if (!rst_s) begin
      m_dig  = '0;
      m_val  = '0;
      m_err  = 1'b0;
      m_eidx = '0;
      m_uidx = '0;
      exp_q.delete();
    end else begin
      if (clr_s) m_err = 1'b0;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (e[24:9] == cyc[15:0]) begin
          void'(exp_q.pop_front());
          k  = e[8:7];
          ix = e[5:4];
          if (k == K_ILL) begin
            m_err  = 1'b1;
            m_eidx = ix;
          end else begin
            m_dig[4*ix +: 4] = (k == K_VAL) ? e[3:0] : 4'd0;
            m_val[ix]        = (k == K_VAL);
            m_uidx           = ix;
            exp_upd          = 1'b1;
          end
        end
      end
    end
    if (update === 1'b1) begin
      upd_cnt++;
      last_upd_cyc = cyc;
    end
    n_total++;
    if (update !== exp_upd) $display("FAIL update cyc=%0d got=%b exp=%b", cyc, update, exp_upd);
    else n_pass++;
    n_total++;
    if (update_idx !== m_uidx) $display("FAIL update_idx cyc=%0d got=%0d exp=%0d", cyc, update_idx, m_uidx);
    else n_pass++;
    n_total++;
    if (digits !== m_dig) $display("FAIL digits cyc=%0d got=%h exp=%h", cyc, digits, m_dig);
    else n_pass++;
    n_total++;
    if (valid !== m_val) $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid, m_val);
    else n_pass++;
    n_total++;
    if (err !== m_err) $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, m_err);
    else n_pass++;
    n_total++;
    if (err_idx !== m_eidx) $display("FAIL err_idx cyc=%0d got=%0d exp=%0d", cyc, err_idx, m_eidx);
    else n_pass++;
  end

  task automatic test_reset();
    repeat (3) drive(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk); #2;
    n_total++;
    if ({digits, valid, update, err} !== 22'd0)
      $display("FAIL reset_hold got=%h exp=0", {digits, valid, update, err});
    else n_pass++;
    repeat (5) drive(7'b0100100, 4'b0000, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if ({digits, valid, update, err} !== 22'd0)
      $display("FAIL reset_release got=%h exp=0", {digits, valid, update, err});
    else n_pass++;
  endtask

  task automatic test_commit();
    int e0;
    int u0;
    u0 = upd_cnt;
    drive(7'b0100100, 4'b0001, 1'b0, 1'b1);
    e0 = cyc + 1;
    repeat (19) drive(7'b0100100, 4'b0001, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (upd_cnt - u0 !== 1) $display("FAIL commit_pulses got=%0d exp=1", upd_cnt - u0);
    else n_pass++;
    n_total++;
    if (last_upd_cyc !== e0 + 8) $display("FAIL commit_latency got=%0d exp=%0d", last_upd_cyc, e0 + 8);
    else n_pass++;
    n_total++;
    if (digits[3:0] !== 4'd2 || valid !== 4'b0001 || update_idx !== 2'd0)
      $display("FAIL commit_value got=%h/%b/%0d exp=2/0001/0", digits[3:0], valid, update_idx);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int e0;
    int u0;
    u0 = upd_cnt;
    repeat (5) drive(7'b1011000, 4'b0010, 1'b0, 1'b1);
    drive(7'b1111001, 4'b0010, 1'b0, 1'b1);
    drive(7'b1011000, 4'b0010, 1'b0, 1'b1);
    e0 = cyc + 1;
    repeat (9) drive(7'b1011000, 4'b0010, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (upd_cnt - u0 !== 1) $display("FAIL glitch_pulses got=%0d exp=1", upd_cnt - u0);
    else n_pass++;
    n_total++;
    if (last_upd_cyc !== e0 + 8) $display("FAIL glitch_latency got=%0d exp=%0d", last_upd_cyc, e0 + 8);
    else n_pass++;
    n_total++;
    if (digits[7:0] !== 8'h72 || valid !== 4'b0011)
      $display("FAIL glitch_value got=%h/%b exp=72/0011", digits[7:0], valid);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int u0;
    u0 = upd_cnt;
    repeat (10) drive(7'b0001000, 4'b0100, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (err !== 1'b1 || err_idx !== 2'd2) $display("FAIL illegal_err got=%b/%0d exp=1/2", err, err_idx);
    else n_pass++;
    n_total++;
    if (upd_cnt - u0 !== 0 || valid[2] !== 1'b0)
      $display("FAIL illegal_noupd got=%0d/%b exp=0/0", upd_cnt - u0, valid[2]);
    else n_pass++;
    // Second illegal pattern on digit 3, err_clr asserted on its commit edge
    repeat (8) drive(7'b0000110, 4'b1000, 1'b0, 1'b1);
    drive(7'b0000110, 4'b1000, 1'b1, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (err !== 1'b1 || err_idx !== 2'd3) $display("FAIL illegal_setwins got=%b/%0d exp=1/3", err, err_idx);
    else n_pass++;
    drive(7'b0000110, 4'b1000, 1'b1, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (err !== 1'b0 || err_idx !== 2'd3) $display("FAIL err_clear got=%b/%0d exp=0/3", err, err_idx);
    else n_pass++;
    drive(7'b0000110, 4'b1000, 1'b0, 1'b1);
  endtask

  task automatic test_blank();
    int u0;
    u0 = upd_cnt;
    repeat (12) drive(7'b1111111, 4'b0001, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (upd_cnt - u0 !== 1 || update_idx !== 2'd0)
      $display("FAIL blank_pulse got=%0d/%0d exp=1/0", upd_cnt - u0, update_idx);
    else n_pass++;
    n_total++;
    if (digits[7:0] !== 8'h70 || valid !== 4'b0010)
      $display("FAIL blank_value got=%h/%b exp=70/0010", digits[7:0], valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int u0;
    int p0;
    int v;
    logic [6:0] seg;
    u0 = upd_cnt;
    p0 = n_pred;
    for (int it = 0; it < 14; it++) begin
      v   = $urandom_range(0, 10);
      seg = (v == 10) ? 7'b1111111 : SEG_TAB[v];
      repeat ($urandom_range(2, 14)) drive(seg, 4'(1 << $urandom_range(0, 3)), 1'b0, 1'b1);
    end
    repeat (3) drive(7'b1111111, 4'b0000, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (upd_cnt - u0 !== n_pred - p0)
      $display("FAIL random_count got=%0d exp=%0d", upd_cnt - u0, n_pred - p0);
    else n_pass++;
  endtask

  task automatic test_bad_enables();
    int u0;
    u0 = upd_cnt;
    repeat (20) drive(7'b0110000, 4'b0011, 1'b0, 1'b1);
    repeat (20) drive(7'b0110000, 4'b0000, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (upd_cnt - u0 !== 0 || err !== 1'b0)
      $display("FAIL bad_enables got=%0d/%b exp=0/0", upd_cnt - u0, err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int e0;
    int u0;
    repeat (7) drive(7'b0010000, 4'b1000, 1'b0, 1'b1);
    repeat (2) drive(7'b0010000, 4'b1000, 1'b0, 1'b0);
    u0 = upd_cnt;
    drive(7'b0010000, 4'b1000, 1'b0, 1'b1);
    e0 = cyc + 1;
    repeat (11) drive(7'b0010000, 4'b1000, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (upd_cnt - u0 !== 1 || last_upd_cyc !== e0 + 8)
      $display("FAIL midreset_latency got=%0d@%0d exp=1@%0d", upd_cnt - u0, last_upd_cyc, e0 + 8);
    else n_pass++;
    n_total++;
    if (digits !== 16'h9000 || valid !== 4'b1000)
      $display("FAIL midreset_value got=%h/%b exp=9000/1000", digits, valid);
    else n_pass++;
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_commit();
    test_glitch();
    test_illegal();
    test_blank();
    test_random();
    test_bad_enables();
    test_reset_mid_run();
    repeat (3) drive(7'b1111111, 4'b0000, 1'b0, 1'b1);
    @(posedge clk); #2;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
